// File: rtl/mpu_bank_bridge_pkg.sv
// rtl/mpu_bank_bridge_pkg.sv - shared types and defaults for the MPU bank bridge
// Purpose: access FSM state encoding, access classification, default register
//          addresses, unmapped read value and default region table.
// Optional feature macro: MPU_BANK_BRIDGE_AUTOINC_EN (pointer/data-port pair
//          placed right after the bank registers).
package mpu_bank_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // What the captured access talks to.
  typedef enum logic [1:0] {
    K_TARGET   = 2'd0,
    K_BANK     = 2'd1,
    K_PTR      = 2'd2,
    K_UNMAPPED = 2'd3
  } kind_e;

  localparam logic [15:0] DEF_UNMAPPED_VALUE = 16'hDEAD;
  localparam logic [15:0] DEF_BANK_REG_ADDR  = 16'h0FF0;

  // Default region table for 20-bit internal addresses, target 7 leftmost.
  // Target 3 overlaps target 2 on purpose: the lower index wins there.
  localparam logic [8*20-1:0] DEF_TARGET_BASES = {
    20'hF0000, 20'h08000, 20'h04000, 20'h01000,
    20'h00000, 20'h00000, 20'h00A00, 20'h00800
  };
  localparam logic [8*20-1:0] DEF_TARGET_SIZES = {
    20'h10000, 20'h78000, 20'h04000, 20'h03000,
    20'h00800, 20'h00100, 20'h00400, 20'h00200
  };

endpackage

// File: rtl/mpu_bank_bridge_if.sv
// rtl/mpu_bank_bridge_if.sv - MPU bus and target bus bundle
// Purpose: groups the external MPU handshake and the internal target strobes.
// Ports (signals):
//   mpu_en/mpu_rd/mpu_wr/mpu_be/mpu_addr_in/mpu_data_in : MPU request
//   mpu_data_out/mpu_ready                               : MPU response
//   tgt_sel/tgt_rd/tgt_wr/tgt_be/tgt_addr/tgt_wdata      : target request
//   tgt_rdata                                            : per-target read data
// Modports: master = MPU and targets side, slave = bridge.
interface mpu_bank_bridge_if #(
  parameter int MPU_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int INT_ADDR_WIDTH = 20,
  parameter int NUM_TARGETS    = 8
);
  logic                              mpu_en;
  logic                              mpu_rd;
  logic                              mpu_wr;
  logic [1:0]                        mpu_be;
  logic [MPU_ADDR_WIDTH-1:0]         mpu_addr_in;
  logic [DATA_WIDTH-1:0]             mpu_data_in;
  logic [DATA_WIDTH-1:0]             mpu_data_out;
  logic                              mpu_ready;
  logic [NUM_TARGETS-1:0]            tgt_sel;
  logic                              tgt_rd;
  logic                              tgt_wr;
  logic [1:0]                        tgt_be;
  logic [INT_ADDR_WIDTH-1:0]         tgt_addr;
  logic [DATA_WIDTH-1:0]             tgt_wdata;
  logic [NUM_TARGETS*DATA_WIDTH-1:0] tgt_rdata;

  modport master (
    output mpu_en, mpu_rd, mpu_wr, mpu_be, mpu_addr_in, mpu_data_in, tgt_rdata,
    input  mpu_data_out, mpu_ready, tgt_sel, tgt_rd, tgt_wr, tgt_be, tgt_addr, tgt_wdata
  );

  modport slave (
    input  mpu_en, mpu_rd, mpu_wr, mpu_be, mpu_addr_in, mpu_data_in, tgt_rdata,
    output mpu_data_out, mpu_ready, tgt_sel, tgt_rd, tgt_wr, tgt_be, tgt_addr, tgt_wdata
  );
endinterface

// File: rtl/mpu_region_decoder.sv
// rtl/mpu_region_decoder.sv - combinational table-driven region decoder
// Purpose: finds the first region with BASE <= addr < BASE + SIZE.
// Ports:
//   addr_i     : internal address
//   sel_o      : one-hot region select (lowest matching index)
//   rel_addr_o : addr_i minus the selected base
//   unmapped_o : no region matched
module mpu_region_decoder #(
  parameter int INT_ADDR_WIDTH = 20,
  parameter int NUM_TARGETS    = 8,
  parameter logic [NUM_TARGETS*INT_ADDR_WIDTH-1:0] TARGET_BASES = '0,
  parameter logic [NUM_TARGETS*INT_ADDR_WIDTH-1:0] TARGET_SIZES = '0
) (
  input  logic [INT_ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_TARGETS-1:0]    sel_o,
  output logic [INT_ADDR_WIDTH-1:0] rel_addr_o,
  output logic                      unmapped_o
);

  logic                    found;
  logic [INT_ADDR_WIDTH:0] base_v;
  logic [INT_ADDR_WIDTH:0] limit_v;

  // One extra bit so a region ending exactly at the top of the space
  // does not wrap its limit to zero.
  always_comb begin
    sel_o      = '0;
    rel_addr_o = '0;
    found      = 1'b0;
    base_v     = '0;
    limit_v    = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      base_v  = {1'b0, TARGET_BASES[i*INT_ADDR_WIDTH +: INT_ADDR_WIDTH]};
      limit_v = base_v + {1'b0, TARGET_SIZES[i*INT_ADDR_WIDTH +: INT_ADDR_WIDTH]};
      if (!found && ({1'b0, addr_i} >= base_v) && ({1'b0, addr_i} < limit_v)) begin
        found      = 1'b1;
        sel_o[i]   = 1'b1;
        rel_addr_o = addr_i - base_v[INT_ADDR_WIDTH-1:0];
      end
    end
    unmapped_o = !found;
  end

endmodule

// File: rtl/mpu_bank_bridge.sv
// rtl/mpu_bank_bridge.sv - banked MPU front end with region decode and handshake
// Purpose: translates MPU page/offset through bank registers, decodes the
//          internal address to a target region and runs a fixed-latency
//          IDLE -> ACCESS -> DONE handshake with registered strobes and data.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   bus         : mpu_bank_bridge_if.slave (MPU request/response, target bus)
//   bank_values : flattened bank registers, window 0 in the low bits
//   access_err  : sticky error (unmapped access or read+write together)
// Optional feature macro: MPU_BANK_BRIDGE_AUTOINC_EN adds a pointer register at
//   BANK_REG_ADDR+NUM_WINDOWS and an auto-incrementing data port at +1.
module mpu_bank_bridge
  import mpu_bank_bridge_pkg::*;
#(
  parameter int MPU_ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH        = 16,
  parameter int PAGE_OFFSET_WIDTH = 12,
  parameter int NUM_WINDOWS       = 4,
  parameter int BANK_WIDTH        = 8,
  parameter int NUM_TARGETS       = 8,
  parameter logic [NUM_TARGETS*(PAGE_OFFSET_WIDTH+BANK_WIDTH)-1:0] TARGET_BASES = DEF_TARGET_BASES,
  parameter logic [NUM_TARGETS*(PAGE_OFFSET_WIDTH+BANK_WIDTH)-1:0] TARGET_SIZES = DEF_TARGET_SIZES,
  parameter int READ_LATENCY      = 1,
  parameter logic [MPU_ADDR_WIDTH-1:0] BANK_REG_ADDR  = DEF_BANK_REG_ADDR,
  parameter logic [DATA_WIDTH-1:0]     UNMAPPED_VALUE = DEF_UNMAPPED_VALUE
) (
  input  logic                              clk,
  input  logic                              reset,
  mpu_bank_bridge_if.slave                  bus,
  output logic [NUM_WINDOWS*BANK_WIDTH-1:0] bank_values,
  output logic                              access_err
);

  localparam int INT_ADDR_WIDTH = PAGE_OFFSET_WIDTH + BANK_WIDTH;
  localparam int PAGE_WIDTH     = MPU_ADDR_WIDTH - PAGE_OFFSET_WIDTH;
  localparam int TIDX_W         = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int BIDX_W         = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;

  state_e                    state_q;
  kind_e                     kind_q;
  logic [2:0]                cnt_q;
  logic [TIDX_W-1:0]         tidx_q;
  logic [BIDX_W-1:0]         bidx_q;
  logic [BANK_WIDTH-1:0]     bank_q [NUM_WINDOWS];

  logic [PAGE_WIDTH-1:0]        page_d;
  logic [PAGE_OFFSET_WIDTH-1:0] offset_d;
  logic                         page_mapped_d;
  logic [BANK_WIDTH-1:0]        bank_sel_d;
  logic [INT_ADDR_WIDTH-1:0]    internal_d;
  logic                         bank_hit_d;
  logic [BIDX_W-1:0]            bank_idx_d;
  logic                         req_d;
  logic                         rd_d;
  logic                         wr_only_d;
  kind_e                        kind_d;
  logic [TIDX_W-1:0]            tidx_d;
  logic [2:0]                   done_cnt_d;
  logic [NUM_TARGETS-1:0]       dec_sel;
  logic [INT_ADDR_WIDTH-1:0]    dec_rel;
  logic                         dec_unmapped;
`ifdef MPU_BANK_BRIDGE_AUTOINC_EN
  logic [INT_ADDR_WIDTH-1:0]    ptr_q;
  logic                         port_q;
  logic                         ptr_hit_d;
  logic                         port_hit_d;
`else
  logic                         reserved_hit_d;
`endif

  assign page_d    = bus.mpu_addr_in[MPU_ADDR_WIDTH-1:PAGE_OFFSET_WIDTH];
  assign offset_d  = bus.mpu_addr_in[PAGE_OFFSET_WIDTH-1:0];
  assign req_d     = bus.mpu_en && (bus.mpu_rd || bus.mpu_wr);
  assign rd_d      = bus.mpu_rd;
  // Read wins when both strobes are set, so the write half is dropped.
  assign wr_only_d = bus.mpu_wr && !bus.mpu_rd;

  // Page translation and register-window hits, evaluated on live inputs;
  // only consulted in IDLE, where the access is captured.
  always_comb begin
    page_mapped_d = (page_d == '0);
    bank_sel_d    = '0;
    for (int k = 0; k < NUM_WINDOWS; k++) begin
      if (page_d == PAGE_WIDTH'(k + 1)) begin
        page_mapped_d = 1'b1;
        bank_sel_d    = bank_q[k];
      end
    end
    internal_d = {bank_sel_d, offset_d};
    bank_hit_d = 1'b0;
    bank_idx_d = '0;
    for (int k = 0; k < NUM_WINDOWS; k++) begin
      if (bus.mpu_addr_in == BANK_REG_ADDR + MPU_ADDR_WIDTH'(k)) begin
        bank_hit_d = 1'b1;
        bank_idx_d = BIDX_W'(k);
      end
    end
`ifdef MPU_BANK_BRIDGE_AUTOINC_EN
    ptr_hit_d  = (bus.mpu_addr_in == BANK_REG_ADDR + MPU_ADDR_WIDTH'(NUM_WINDOWS));
    port_hit_d = (bus.mpu_addr_in == BANK_REG_ADDR + MPU_ADDR_WIDTH'(NUM_WINDOWS + 1));
    if (port_hit_d) internal_d = ptr_q;
`else
    reserved_hit_d = (bus.mpu_addr_in == BANK_REG_ADDR + MPU_ADDR_WIDTH'(NUM_WINDOWS)) ||
                     (bus.mpu_addr_in == BANK_REG_ADDR + MPU_ADDR_WIDTH'(NUM_WINDOWS + 1));
`endif
  end

  mpu_region_decoder #(
    .INT_ADDR_WIDTH (INT_ADDR_WIDTH),
    .NUM_TARGETS    (NUM_TARGETS),
    .TARGET_BASES   (TARGET_BASES),
    .TARGET_SIZES   (TARGET_SIZES)
  ) u_decoder (
    .addr_i     (internal_d),
    .sel_o      (dec_sel),
    .rel_addr_o (dec_rel),
    .unmapped_o (dec_unmapped)
  );

  // Register windows take priority over the region table.
  always_comb begin
    kind_d = K_TARGET;
    if (bank_hit_d) kind_d = K_BANK;
`ifdef MPU_BANK_BRIDGE_AUTOINC_EN
    else if (ptr_hit_d) kind_d = K_PTR;
    else if (port_hit_d) kind_d = dec_unmapped ? K_UNMAPPED : K_TARGET;
`else
    else if (reserved_hit_d) kind_d = K_UNMAPPED;
`endif
    else if (!page_mapped_d || dec_unmapped) kind_d = K_UNMAPPED;
  end

  always_comb begin
    tidx_d = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (dec_sel[i]) tidx_d = TIDX_W'(i);
    end
  end

  // cnt_q starts at 0 on capture, so DONE is reached latency+2 clocks after
  // capture; register windows behave as latency-1 targets.
  assign done_cnt_d = ((kind_q == K_BANK) || (kind_q == K_PTR)) ? 3'd2 : 3'(READ_LATENCY + 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      kind_q           <= K_TARGET;
      cnt_q            <= '0;
      tidx_q           <= '0;
      bidx_q           <= '0;
      access_err       <= 1'b0;
      bus.mpu_ready    <= 1'b0;
      bus.mpu_data_out <= '0;
      bus.tgt_sel      <= '0;
      bus.tgt_rd       <= 1'b0;
      bus.tgt_wr       <= 1'b0;
      bus.tgt_be       <= '0;
      bus.tgt_addr     <= '0;
      bus.tgt_wdata    <= '0;
      for (int k = 0; k < NUM_WINDOWS; k++) bank_q[k] <= '0;
`ifdef MPU_BANK_BRIDGE_AUTOINC_EN
      ptr_q            <= '0;
      port_q           <= 1'b0;
`endif
    end else begin
      // Target strobes are single-cycle pulses.
      bus.tgt_sel <= '0;
      bus.tgt_rd  <= 1'b0;
      bus.tgt_wr  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_d) begin
            state_q <= ST_ACCESS;
            cnt_q   <= '0;
            kind_q  <= kind_d;
            tidx_q  <= tidx_d;
            bidx_q  <= bank_idx_d;
`ifdef MPU_BANK_BRIDGE_AUTOINC_EN
            port_q  <= port_hit_d;
`endif
            if (bus.mpu_rd && bus.mpu_wr) access_err <= 1'b1;
            case (kind_d)
              K_TARGET: begin
                bus.tgt_sel   <= dec_sel;
                bus.tgt_rd    <= rd_d;
                bus.tgt_wr    <= wr_only_d;
                bus.tgt_be    <= bus.mpu_be;
                bus.tgt_addr  <= dec_rel;
                bus.tgt_wdata <= bus.mpu_data_in;
              end
              K_BANK: begin
                if (wr_only_d) begin
                  for (int b = 0; b < BANK_WIDTH; b++) begin
                    if (bus.mpu_be[b/8]) bank_q[bank_idx_d][b] <= bus.mpu_data_in[b];
                  end
                  // Empty-byte-enable write to window 0 is the error clear.
                  if (bank_idx_d == '0 && bus.mpu_be == 2'b00) access_err <= 1'b0;
                end
              end
`ifdef MPU_BANK_BRIDGE_AUTOINC_EN
              K_PTR: begin
                // Low bytes follow mpu_be; an empty-be write loads the bits
                // above DATA_WIDTH from the low bits of the write data.
                if (wr_only_d) begin
                  for (int b = 0; b < INT_ADDR_WIDTH; b++) begin
                    if (b < DATA_WIDTH) begin
                      if (bus.mpu_be[b/8]) ptr_q[b] <= bus.mpu_data_in[b];
                    end else if (bus.mpu_be == 2'b00) begin
                      ptr_q[b] <= bus.mpu_data_in[b-DATA_WIDTH];
                    end
                  end
                end
              end
`endif
              default: access_err <= 1'b1;
            endcase
          end
        end
        ST_ACCESS: begin
          if (cnt_q == done_cnt_d) begin
            state_q       <= ST_DONE;
            bus.mpu_ready <= 1'b1;
            case (kind_q)
              K_TARGET: bus.mpu_data_out <= bus.tgt_rdata[tidx_q*DATA_WIDTH +: DATA_WIDTH];
              K_BANK:   bus.mpu_data_out <= DATA_WIDTH'(bank_q[bidx_q]);
`ifdef MPU_BANK_BRIDGE_AUTOINC_EN
              K_PTR:    bus.mpu_data_out <= ptr_q[DATA_WIDTH-1:0];
`endif
              default:  bus.mpu_data_out <= UNMAPPED_VALUE;
            endcase
`ifdef MPU_BANK_BRIDGE_AUTOINC_EN
            if (port_q) ptr_q <= ptr_q + 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_DONE: begin
          if (!bus.mpu_en) begin
            state_q       <= ST_IDLE;
            bus.mpu_ready <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_WINDOWS; k++) begin : g_bank_out
    assign bank_values[k*BANK_WIDTH +: BANK_WIDTH] = bank_q[k];
  end

endmodule

// File: tb/tb_mpu_bank_bridge.sv
// tb/tb_mpu_bank_bridge.sv - self-checking bench for mpu_bank_bridge
module tb_mpu_bank_bridge;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mpu_bank_bridge_if bus ();
  logic [31:0] bank_values;
  logic        access_err;

  mpu_bank_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .bank_values (bank_values),
    .access_err  (access_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: region table, bank registers, sticky error, target data.
  int          bases [8] = '{'h00800, 'h00A00, 'h00000, 'h00000, 'h01000, 'h04000, 'h08000, 'hF0000};
  int          sizes [8] = '{'h00200, 'h00400, 'h00100, 'h00800, 'h03000, 'h04000, 'h78000, 'h10000};
  logic [7:0]  m_bank [4];
  bit          m_err;
  logic [15:0] rdat [8];

  logic [7:0]  obs_sel;
  logic        obs_rd, obs_wr;
  logic [19:0] obs_addr;
  logic [15:0] obs_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bank_flat();
    return {m_bank[3], m_bank[2], m_bank[1], m_bank[0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_bank[k] = 8'h00;
    m_err = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ready"}, bus.mpu_ready, 0);
    check({tag, " data_out"}, bus.mpu_data_out, 0);
    check({tag, " tgt_sel"}, bus.tgt_sel, 0);
    check({tag, " tgt_rd/wr/be"}, {bus.tgt_rd, bus.tgt_wr, bus.tgt_be}, 0);
    check({tag, " tgt_addr/wdata"}, {bus.tgt_addr, bus.tgt_wdata}, 0);
    check({tag, " bank_values"}, bank_values, 0);
    check({tag, " access_err"}, access_err, 0);
  endtask

  // One complete access; inputs are scrambled while it is in flight.
  task automatic run_access(input bit rd, input bit wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [1:0] be);
    int kind, tix, bix, rel, internal, page, lat;
    logic [15:0] exp_data;
    logic [7:0]  exp_sel;
    bit          found;
    // kind: 0 target, 1 bank register, 2 unmapped
    kind = 2; tix = 0; bix = 0; rel = 0;
    if (addr >= 16'h0FF0 && addr <= 16'h0FF3) begin
      kind = 1; bix = int'(addr) - 'h0FF0;
    end else if (addr != 16'h0FF4 && addr != 16'h0FF5) begin
      page = int'(addr) >> 12;
      internal = -1;
      if (page == 0) internal = int'(addr);
      else if (page <= 4) internal = int'(m_bank[page-1]) * 4096 + (int'(addr) & 'hFFF);
      found = 0;
      if (internal >= 0) begin
        for (int i = 0; i < 8; i++) begin
          if (!found && internal >= bases[i] && internal < bases[i] + sizes[i]) begin
            found = 1; kind = 0; tix = i; rel = internal - bases[i];
          end
        end
      end
    end
    lat = 3;
    for (int i = 0; i < 8; i++) rdat[i] = 16'($urandom);
    exp_sel  = (kind == 0) ? (8'b1 << tix) : 8'h00;
    exp_data = (kind == 0) ? rdat[tix] : (kind == 1) ? {8'h00, m_bank[bix]} : 16'hDEAD;

    @(negedge clk);
    for (int i = 0; i < 8; i++) bus.tgt_rdata[i*16 +: 16] = rdat[i];
    bus.mpu_en = 1'b1; bus.mpu_rd = rd; bus.mpu_wr = wr;
    bus.mpu_addr_in = addr; bus.mpu_data_in = wdata; bus.mpu_be = be;
    @(posedge clk);
    if (rd && wr) m_err = 1'b1;
    if (kind == 2) m_err = 1'b1;
    if (kind == 1 && wr && !rd) begin
      if (be[0]) m_bank[bix] = wdata[7:0];
      if (bix == 0 && be == 2'b00) m_err = 1'b0;
    end

    for (int n = 0; n <= lat; n++) begin
      @(negedge clk);
      check("tgt_sel", bus.tgt_sel, (n == 0) ? exp_sel : 8'h00);
      check("tgt_rd", bus.tgt_rd, (n == 0) && kind == 0 && rd);
      check("tgt_wr", bus.tgt_wr, (n == 0) && kind == 0 && wr && !rd);
      check("mpu_ready", bus.mpu_ready, n == lat);
      check("access_err", access_err, m_err);
      check("bank_values", bank_values, bank_flat());
      if (n == 0) begin
        obs_sel = bus.tgt_sel; obs_rd = bus.tgt_rd; obs_wr = bus.tgt_wr; obs_addr = bus.tgt_addr;
        if (kind == 0) begin
          check("tgt_addr", bus.tgt_addr, 20'(rel));
          check("tgt_be", bus.tgt_be, be);
          check("tgt_wdata", bus.tgt_wdata, wdata);
        end
      end
      if (n == lat) begin
        obs_data = bus.mpu_data_out;
        if (rd) check("mpu_data_out", bus.mpu_data_out, exp_data);
        bus.mpu_en = 1'b0;
      end else begin
        bus.mpu_rd = 1'($urandom); bus.mpu_wr = 1'($urandom);
        bus.mpu_addr_in = 16'($urandom); bus.mpu_data_in = 16'($urandom); bus.mpu_be = 2'($urandom);
      end
    end
    bus.mpu_rd = 1'b0; bus.mpu_wr = 1'b0;
    @(negedge clk);
    check("ready_drop", bus.mpu_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mpu_en = 0; bus.mpu_rd = 0; bus.mpu_wr = 0; bus.mpu_be = 0;
    bus.mpu_addr_in = 0; bus.mpu_data_in = 0; bus.tgt_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Read page 0 into target 2
    run_access(1, 0, 16'h0010, 16'h0, 2'b11);
    check("lit t2 sel", obs_sel, 8'b0000_0100);
    check("lit t2 data", obs_data, rdat[2]);
    // Region boundaries and overlap priority
    run_access(1, 0, 16'h00FF, 16'h0, 2'b11);
    check("lit 0x0ff sel", {obs_sel, obs_addr}, {8'b0000_0100, 20'h000FF});
    run_access(1, 0, 16'h0100, 16'h0, 2'b11);
    check("lit 0x100 sel", {obs_sel, obs_addr}, {8'b0000_1000, 20'h00100});
    // Bank 1 = 5, then page 2 maps to internal 0x05034 in target 5
    run_access(0, 1, 16'h0FF1, 16'hAB05, 2'b11);
    check("lit bank1", bank_values, 32'h0000_0500);
    run_access(1, 0, 16'h2034, 16'h0, 2'b11);
    check("lit 0x2034", {obs_sel, obs_addr}, {8'b0010_0000, 20'h01034});
    run_access(1, 0, 16'h0FF1, 16'h0, 2'b11);
    check("lit bank1 read", obs_data, 16'h0005);
    // Unmapped page and error clear
    run_access(1, 0, 16'h7000, 16'h0, 2'b11);
    check("lit unmapped", {obs_sel, obs_data, 7'd0, access_err}, {8'h00, 16'hDEAD, 8'h01});
    run_access(0, 1, 16'h0FF0, 16'h1234, 2'b00);
    check("lit err clear", {access_err, bank_values}, {1'b0, 32'h0000_0500});
    // Read and write together
    run_access(1, 1, 16'h0010, 16'h5555, 2'b11);
    check("lit rd+wr", {obs_rd, obs_wr, access_err}, 3'b101);
    run_access(0, 1, 16'h0FF0, 16'h0, 2'b00);
    // Unmapped write and reserved register slots
    run_access(0, 1, 16'h0FF4, 16'h1111, 2'b11);
    check("lit unmapped wr", {obs_sel, obs_wr, access_err}, {8'h00, 1'b0, 1'b1});

    // Reset while in ACCESS
    @(negedge clk);
    bus.mpu_en = 1; bus.mpu_rd = 1; bus.mpu_wr = 0; bus.mpu_addr_in = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; bus.mpu_en = 0; bus.mpu_rd = 0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid reset");
    reset = 1'b1;
    model_reset();
    run_access(1, 0, 16'h0010, 16'h0, 2'b11);
    check("lit post reset", obs_sel, 8'b0000_0100);

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      int  pick, op;
      logic [15:0] a;
      pick = $urandom_range(0, 9);
      if (pick < 3) a = 16'h0FF0 + 16'($urandom_range(0, 5));
      else if (pick < 5) a = 16'($urandom_range(0, 'h0FFF));
      else a = 16'($urandom);
      op = $urandom_range(0, 4);
      run_access(op < 2 || op == 4, op >= 2, a, 16'($urandom), 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mpu_bank_bridge.md
Name: mpu_bank_bridge

Overview:
- Parametrised MPU-side front end for the ChronoCube top level.
- Replaces the combinational page/bank mapping and select-chain readback with:
  - a registered, multi-window bank translator;
  - a table-driven region decoder;
  - a read/write handshake with per-access latency and a ready signal.
- Sits between the external MPU bus and the internal targets (palette, tilemap, sprite RAM, registers, VRAM window, collision table).

Parameters:
- MPU_ADDR_WIDTH, 16: external address width.
- DATA_WIDTH, 16: bus data width.
- PAGE_OFFSET_WIDTH, 12: page offset bits.
- NUM_WINDOWS, 4: banked windows. Page 0 is fixed to internal 0; pages 1..NUM_WINDOWS use bank registers; higher pages are unmapped.
- BANK_WIDTH, 8: width of each bank register.
- NUM_TARGETS, 8: number of decoded regions.
- TARGET_BASES, flat NUM_TARGETS*INT_ADDR_WIDTH vector: region base addresses.
- TARGET_SIZES, flat vector of the same width: region lengths.
- READ_LATENCY, 1: cycles from target strobe to target data valid, range 1..4.
- BANK_REG_ADDR, 'h0FF0: page-0 address of bank register 0; window k sits at +k.
- UNMAPPED_VALUE, 'hdead: read data for unmapped accesses.
- Derived: INT_ADDR_WIDTH = PAGE_OFFSET_WIDTH + BANK_WIDTH.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-low reset.
- mpu_en, input, 1: access enable.
- mpu_rd, input, 1: read strobe.
- mpu_wr, input, 1: write strobe.
- mpu_be, input, 2: byte enables.
- mpu_addr_in, input, MPU_ADDR_WIDTH: external address.
- mpu_data_in, input, DATA_WIDTH: write data.
- mpu_data_out, output, DATA_WIDTH: registered read data.
- mpu_ready, output, 1: access complete.
- tgt_sel, output, NUM_TARGETS: one-hot region strobe.
- tgt_rd, output, 1: target read strobe.
- tgt_wr, output, 1: target write strobe.
- tgt_be, output, 2: target byte enables.
- tgt_addr, output, INT_ADDR_WIDTH: address relative to the selected region base.
- tgt_wdata, output, DATA_WIDTH: target write data.
- tgt_rdata, input, NUM_TARGETS*DATA_WIDTH: per-target read data, flattened.
- bank_values, output, NUM_WINDOWS*BANK_WIDTH: current bank registers, for debug/status.
- access_err, output, 1: sticky error flag.

Behaviour:
- Reset (reset==0 at a clk edge) forces:
  - state IDLE;
  - mpu_ready=0, mpu_data_out=0;
  - tgt_sel=0, tgt_rd=0, tgt_wr=0, tgt_be=0, tgt_addr=0, tgt_wdata=0;
  - all bank registers=0, access_err=0.
- A reset arriving mid-access aborts it. No target strobe is issued in the cycle after reset.
- Translation:
  - internal = {bank_or_zero, page_offset}.
  - Page 0 uses bank 0. Page p in 1..NUM_WINDOWS uses bank_reg[p-1]. Any other page is unmapped.
- Decode:
  - First region matching TARGET_BASES[i] <= internal < BASE[i] + SIZE[i] wins; lowest index has priority.
  - tgt_addr = internal - BASE[i].
- Bank register access: page-0 offsets BANK_REG_ADDR..+NUM_WINDOWS-1.
  - Write: updates bytes per mpu_be; only bits BANK_WIDTH-1:0 are stored.
  - Read: returns the zero-extended value.
  - Completes in ACCESS with latency 1. Takes priority over target decode.
- Access FSM:
  - IDLE: on mpu_en & (mpu_rd|mpu_wr), capture address, data, be and strobes, then go to ACCESS. Targets see tgt_sel/tgt_rd/tgt_wr for exactly one cycle, registered, the cycle after capture.
  - ACCESS: count READ_LATENCY cycles, then latch the selected tgt_rdata slice (or UNMAPPED_VALUE) into mpu_data_out and go to DONE. Writes also wait READ_LATENCY cycles, so latency is uniform.
  - DONE: mpu_ready=1 and mpu_data_out held. When mpu_en==0, return to IDLE with mpu_ready=0.
- Total latency from capture to mpu_ready: READ_LATENCY+2 clocks.
- mpu_rd & mpu_wr together: performed as a read, write suppressed, access_err set.
- Unmapped write: no tgt_sel asserted, access_err set.
- Unmapped read: returns UNMAPPED_VALUE, access_err set.
- access_err clears only on reset or on a write to bank register 0 with mpu_be==2'b00.
- Inputs that change during ACCESS/DONE are ignored; the captured values are used.

Optional Feature:
- Macro: MPU_BANK_BRIDGE_AUTOINC_EN.
- Defined:
  - Page-0 address BANK_REG_ADDR+NUM_WINDOWS becomes a pointer register, INT_ADDR_WIDTH bits.
  - BANK_REG_ADDR+NUM_WINDOWS+1 becomes a data port.
  - A data-port access uses the pointer as the internal address, then the pointer increments by 1 when DONE is entered, wrapping at 2^INT_ADDR_WIDTH.
  - Used for sequential sprite/palette uploads.
- Undefined: both addresses decode as unmapped and no pointer register exists.

Decomposition:
- Shared package/header mpu_bridge_defs.vh holds:
  - state encodings IDLE/ACCESS/DONE;
  - the default UNMAPPED_VALUE;
  - the default BANK_REG_ADDR offsets;
  - the macro guard.
- One sub-module, mpu_region_decoder: purely combinational, parameterised on TARGET_BASES/TARGET_SIZES. It produces a one-hot select, the relative address, and an unmapped flag.

Test Plan:
- Reset, then read page 0 address 'h0010 mapped to target 2 (base 'h0000, size 'h100), READ_LATENCY=1 -> tgt_sel=8'b00000100 pulses once, mpu_ready rises 3 clocks after capture, mpu_data_out = tgt_rdata[2].
- Write bank_reg[1]='h05, then read mpu_addr 'h2034 -> internal 'h05034; tgt_addr = 'h05034 - base of the matching region.
- Read page 7 (> NUM_WINDOWS) -> mpu_data_out='hdead, access_err=1, no tgt_sel; then write 'h0FF0 with be=2'b00 -> access_err=0.
- mpu_rd & mpu_wr both high on a target -> tgt_wr stays 0, tgt_rd pulses, access_err=1.
- Pull reset low in the ACCESS state -> next cycle all outputs are 0 and state is IDLE; a subsequent access completes normally.
- With MPU_BANK_BRIDGE_AUTOINC_EN: pointer='h0FFFF, two data-port writes -> writes land at 'h0FFFF then 'h10000; at the wrap (pointer = all ones, 'hFFFFF for the default widths) the pointer returns to 0.
